// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for a single-port 2**AW x DW data memory with registered outputs.
// Define DMEM_ARB_FIXED_PRIO_EN to make requester 0 win every tie instead of round-robin.
module dmem_arbiter #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          r0_req,
    input  logic          r0_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_gnt,
    output logic          r0_rvalid,
    output logic [DW-1:0] r0_rdata,
    input  logic          r1_req,
    input  logic          r1_we,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_gnt,
    output logic          r1_rvalid,
    output logic [DW-1:0] r1_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RDATA = 2'd2} state_t;

    state_t        r_state, w_state_next;
    logic          r_owner, r_last_owner, r_busy;
    logic          r_gnt0, r_gnt1, r_rvalid0, r_rvalid1, r_mem_en, r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata, r_rdata0, r_rdata1;

    logic          w_any_req, w_win1;
    logic          w_owner_next, w_last_owner_next;
    logic          w_gnt0_next, w_gnt1_next, w_rvalid0_next, w_rvalid1_next;
    logic          w_mem_en_next, w_mem_we_next;
    logic [AW-1:0] w_mem_addr_next;
    logic [DW-1:0] w_mem_wdata_next, w_rdata0_next, w_rdata1_next;

    assign w_any_req = r0_req | r1_req;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign w_win1 = r1_req & ~r0_req;
`else
    // On a tie the requester that did not own the previous access wins.
    assign w_win1 = r1_req & (~r0_req | ~r_last_owner);
`endif

    always_comb begin
        w_state_next      = r_state;
        w_owner_next      = r_owner;
        w_last_owner_next = r_last_owner;
        w_gnt0_next       = 1'b0;
        w_gnt1_next       = 1'b0;
        w_rvalid0_next    = 1'b0;
        w_rvalid1_next    = 1'b0;
        w_mem_en_next     = 1'b0;
        w_mem_we_next     = 1'b0;
        w_mem_addr_next   = r_mem_addr;
        w_mem_wdata_next  = r_mem_wdata;
        w_rdata0_next     = r_rdata0;
        w_rdata1_next     = r_rdata1;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_state_next      = ACCESS;
                    w_owner_next      = w_win1;
                    w_last_owner_next = w_win1;
                    w_gnt0_next       = ~w_win1;
                    w_gnt1_next       = w_win1;
                    w_mem_en_next     = 1'b1;
                    w_mem_we_next     = w_win1 ? r1_we    : r0_we;
                    w_mem_addr_next   = w_win1 ? r1_addr  : r0_addr;
                    w_mem_wdata_next  = w_win1 ? r1_wdata : r0_wdata;
                end
            end
            ACCESS: w_state_next = r_mem_we ? IDLE : RDATA;
            RDATA: begin
                w_state_next = IDLE;
                if (r_owner) begin
                    w_rdata1_next  = mem_rdata;
                    w_rvalid1_next = 1'b1;
                end else begin
                    w_rdata0_next  = mem_rdata;
                    w_rvalid0_next = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_busy       <= 1'b0;
            r_gnt0       <= 1'b0;
            r_gnt1       <= 1'b0;
            r_rvalid0    <= 1'b0;
            r_rvalid1    <= 1'b0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            r_state      <= w_state_next;
            r_owner      <= w_owner_next;
            r_last_owner <= w_last_owner_next;
            r_busy       <= (w_state_next != IDLE);
            r_gnt0       <= w_gnt0_next;
            r_gnt1       <= w_gnt1_next;
            r_rvalid0    <= w_rvalid0_next;
            r_rvalid1    <= w_rvalid1_next;
            r_mem_en     <= w_mem_en_next;
            r_mem_we     <= w_mem_we_next;
            r_mem_addr   <= w_mem_addr_next;
            r_mem_wdata  <= w_mem_wdata_next;
            r_rdata0     <= w_rdata0_next;
            r_rdata1     <= w_rdata1_next;
        end
    end

    assign r0_gnt    = r_gnt0;
    assign r1_gnt    = r_gnt1;
    assign r0_rvalid = r_rvalid0;
    assign r1_rvalid = r_rvalid1;
    assign r0_rdata  = r_rdata0;
    assign r1_rdata  = r_rdata1;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: schedule-based reference model checked every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_dmem_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       r0_req = 1'b0, r0_we = 1'b0, r1_req = 1'b0, r1_we = 1'b0;
    logic [3:0] r0_addr = '0, r1_addr = '0;
    logic [7:0] r0_wdata = '0, r1_wdata = '0;
    logic       r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
    logic [7:0] r0_rdata, r1_rdata;
    logic       mem_en, mem_we, busy;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = '0;

    int n_tests = 0;
    int n_fail  = 0;

    dmem_arbiter #(.AW(4), .DW(8)) dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Physical memory seen by the DUT: registered read, preloaded addr1=11, addr2=22.
    logic [7:0] phys [16] = '{8'h00, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    always @(posedge clk) begin
        if (mem_en && mem_we)  phys[mem_addr] <= mem_wdata;
        else if (mem_en)       mem_rdata <= phys[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each IDLE decision at edge k schedules the expected outputs of
    // periods k (grant), k+1 (busy for reads) and k+2 (read response) into a ring.
    logic [7:0] mm [16] = '{8'h00, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    bit         e_g0 [8], e_g1 [8], e_en [8], e_we [8], e_busy [8], e_rv0 [8], e_rv1 [8];
    logic [3:0] e_addr [8];
    logic [7:0] e_wd [8], e_rd [8];
    int         cyc = 0;
    int         m_next_free = 0;
    logic       m_last = 1'b1;
    logic [3:0] m_addr = '0;
    logic [7:0] m_wdata = '0;
    logic       m_win, m_we;
    logic [3:0] m_a;
    logic [7:0] m_d;

    always_comb begin
        m_win = r1_req;
        if (r0_req && r1_req) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            m_win = 1'b0;
`else
            m_win = ~m_last;
`endif
        end
        m_we = m_win ? r1_we    : r0_we;
        m_a  = m_win ? r1_addr  : r0_addr;
        m_d  = m_win ? r1_wdata : r0_wdata;
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                e_g0[i] <= 0; e_g1[i] <= 0; e_en[i] <= 0; e_we[i] <= 0;
                e_busy[i] <= 0; e_rv0[i] <= 0; e_rv1[i] <= 0;
            end
            m_next_free <= 0;
            m_last      <= 1'b1;
            m_addr      <= '0;
            m_wdata     <= '0;
        end else begin
            cyc <= cyc + 1;
            if (e_en[cyc % 8] && e_we[cyc % 8]) mm[e_addr[cyc % 8]] <= e_wd[cyc % 8];
            e_g0[cyc % 8] <= 0; e_g1[cyc % 8] <= 0; e_en[cyc % 8] <= 0; e_we[cyc % 8] <= 0;
            e_busy[cyc % 8] <= 0; e_rv0[cyc % 8] <= 0; e_rv1[cyc % 8] <= 0;
            if ((cyc + 1 >= m_next_free) && (r0_req || r1_req)) begin
                e_g0[(cyc + 1) % 8]   <= ~m_win;
                e_g1[(cyc + 1) % 8]   <= m_win;
                e_en[(cyc + 1) % 8]   <= 1;
                e_we[(cyc + 1) % 8]   <= m_we;
                e_busy[(cyc + 1) % 8] <= 1;
                e_addr[(cyc + 1) % 8] <= m_a;
                e_wd[(cyc + 1) % 8]   <= m_d;
                if (!m_we) begin
                    e_busy[(cyc + 2) % 8] <= 1;
                    e_rv0[(cyc + 3) % 8]  <= ~m_win;
                    e_rv1[(cyc + 3) % 8]  <= m_win;
                    e_rd[(cyc + 3) % 8]   <= mm[m_a];
                end
                m_next_free <= cyc + 1 + (m_we ? 2 : 3);
                m_last      <= m_win;
                m_addr      <= m_a;
                m_wdata     <= m_d;
            end
        end
    end

    // Per-cycle compare plus event counters used by the directed checks.
    logic [7:0] m_rd0 = '0, m_rd1 = '0;
    int busy_cnt = 0, acc_cnt = 0, g0_cnt = 0, g1_cnt = 0, rv0_cnt = 0, rv1_cnt = 0;
    int rv0_cyc = 0, rv1_cyc = 0, g_total = 0;
    int gnt_hist [64];

    always @(negedge clk) begin : cmp
        int s;
        s = cyc % 8;
        if (!reset) begin
            m_rd0 = '0;
            m_rd1 = '0;
        end else begin
            if (e_rv0[s]) m_rd0 = e_rd[s];
            if (e_rv1[s]) m_rd1 = e_rd[s];
        end
        chk("r0_gnt",    r0_gnt,    e_g0[s]);
        chk("r1_gnt",    r1_gnt,    e_g1[s]);
        chk("mem_en",    mem_en,    e_en[s]);
        chk("mem_we",    mem_we,    e_we[s]);
        chk("busy",      busy,      e_busy[s]);
        chk("r0_rvalid", r0_rvalid, e_rv0[s]);
        chk("r1_rvalid", r1_rvalid, e_rv1[s]);
        chk("r0_rdata",  r0_rdata,  m_rd0);
        chk("r1_rdata",  r1_rdata,  m_rd1);
        chk("mem_addr",  mem_addr,  m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("gnt_overlap", r0_gnt & r1_gnt, 0);
        if (busy) busy_cnt++;
        if (mem_en) acc_cnt++;
        if (r0_gnt || r1_gnt) begin
            if (g_total < 64) gnt_hist[g_total] = r1_gnt ? 1 : 0;
            g_total++;
            $display("[TB] cyc %0d grant r%0d we=%0b addr=%0h wdata=%02h", cyc, r1_gnt ? 1 : 0, mem_we, mem_addr, mem_wdata);
        end
        if (r0_gnt) g0_cnt++;
        if (r1_gnt) g1_cnt++;
        if (r0_rvalid) begin
            rv0_cnt++; rv0_cyc = cyc;
            $display("[TB] cyc %0d rvalid r0 rdata=%02h", cyc, r0_rdata);
        end
        if (r1_rvalid) begin
            rv1_cnt++; rv1_cyc = cyc;
            $display("[TB] cyc %0d rvalid r1 rdata=%02h", cyc, r1_rdata);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // which: 0=r0_gnt 1=r1_gnt 2=r0_rvalid 3=r1_rvalid 4=any gnt
    task automatic wait_for(input int which, input int budget);
        bit hit;
        hit = 0;
        for (int i = 0; i < budget && !hit; i++) begin
            step();
            case (which)
                0: hit = r0_gnt;
                1: hit = r1_gnt;
                2: hit = r0_rvalid;
                3: hit = r1_rvalid;
                default: hit = r0_gnt | r1_gnt;
            endcase
        end
        if (!hit) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout_wait_%0d actual=no_event required=event_within_%0d_cycles", which, budget);
        end
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        int b0, c0, t0, a0, g1s;
        step(); step();
        reset = 1'b1;
        step();
        chk("reset_busy", busy, 0);
        chk("reset_mem_en", mem_en, 0);

        // single write by r0
        b0 = busy_cnt;
        r0_req = 1; r0_we = 1; r0_addr = 4'h3; r0_wdata = 8'hA5;
        step();
        chk("wr_gnt_next_cycle", r0_gnt, 1);
        chk("wr_mem_en", mem_en, 1);
        chk("wr_mem_we", mem_we, 1);
        chk("wr_mem_addr", mem_addr, 4'h3);
        chk("wr_mem_wdata", mem_wdata, 8'hA5);
        r0_req = 0;
        step(); step(); step();
        chk("wr_busy_cycles", busy_cnt - b0, 1);

        // r1 reads it back
        c0 = rv0_cnt;
        r1_req = 1; r1_we = 0; r1_addr = 4'h3;
        wait_for(1, 5);
        t0 = cyc;
        r1_req = 0;
        wait_for(3, 5);
        chk("rd_latency", cyc - t0, 2);
        chk("rd_r1_rdata", r1_rdata, 8'hA5);
        step();
        chk("rd_no_r0_rvalid", rv0_cnt - c0, 0);

        // contention on writes: 8 grants
        g1s = g_total;
        r0_req = 1; r0_we = 1; r0_addr = 4'h5; r0_wdata = 8'h55;
        r1_req = 1; r1_we = 1; r1_addr = 4'h6; r1_wdata = 8'h66;
        for (int i = 0; i < 40 && (g_total - g1s) < 8; i++) step();
        r0_req = 0; r1_req = 0;
        chk("cont_grant_count", g_total - g1s, 8);
        for (int i = 0; i < 8; i++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            chk($sformatf("cont_grant_%0d", i), gnt_hist[g1s + i], 0);
`else
            chk($sformatf("cont_grant_%0d", i), gnt_hist[g1s + i], i % 2);
`endif
        end
        step(); step();

        // concurrent reads
        r0_req = 1; r0_we = 0; r0_addr = 4'h1;
        r1_req = 1; r1_we = 0; r1_addr = 4'h2;
        wait_for(4, 5);
        chk("rr_first_is_r0", r0_gnt, 1);
        r0_req = 0;
        wait_for(1, 6);
        r1_req = 0;
        wait_for(3, 6);
        chk("rr_r0_rdata", r0_rdata, 8'h11);
        chk("rr_r1_rdata", r1_rdata, 8'h22);
        chk("rr_rvalid_spacing", rv1_cyc - rv0_cyc, 3);
        step(); step();

        // async reset during RDATA
        c0 = rv0_cnt;
        r0_req = 1; r0_we = 0; r0_addr = 4'h3;
        wait_for(0, 5);
        r0_req = 0;
        step();
        chk("rst_pre_busy", busy, 1);
        #1 reset = 1'b0;
        #1;
        chk("rst_busy_drop", busy, 0);
        chk("rst_mem_en_drop", mem_en, 0);
        chk("rst_gnt_drop", r0_gnt | r1_gnt, 0);
        step(); step();
        reset = 1'b1;
        step(); step(); step(); step();
        chk("rst_no_rvalid", rv0_cnt - c0, 0);
        r1_req = 1; r1_we = 1; r1_addr = 4'h7; r1_wdata = 8'h77;
        wait_for(1, 5);
        r1_req = 0;
        r0_req = 1; r0_we = 0; r0_addr = 4'h7;
        wait_for(0, 5);
        r0_req = 0;
        wait_for(2, 5);
        chk("post_rst_rdata", r0_rdata, 8'h77);
        step();

        // r1 request pulsed entirely inside r0's ACCESS cycle
        a0 = acc_cnt; c0 = g1_cnt;
        r0_req = 1; r0_we = 1; r0_addr = 4'h8; r0_wdata = 8'h88;
        wait_for(0, 5);
        r0_req = 0;
        #1 r1_req = 1; r1_we = 1; r1_addr = 4'h9; r1_wdata = 8'h99;
        #1 r1_req = 0;
        step(); step(); step(); step();
        chk("wd_access_count", acc_cnt - a0, 1);
        chk("wd_no_r1_gnt", g1_cnt - c0, 0);
        r1_req = 1; r1_we = 0; r1_addr = 4'h8;
        wait_for(1, 5);
        r1_req = 0;
        wait_for(3, 5);
        chk("wd_r1_readback", r1_rdata, 8'h88);
        step(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
